carry_lookahead_adder: RTL and testbench
========================================

Name: carry_lookahead_adder

Overview:
- Parameterised N-bit carry-lookahead adder: sum = a + b + c_in, with carry out.
- Primary result is combinational, for datapath use where a fast carry-propagate adder is needed.
- A registered copy of the result is also provided for timing-closure use; this copy is the only clocked logic.
- Drop-in peer of the ripple-carry adder: same operand/result ordering and identical arithmetic results.

Parameters:
- N, 4, operand and sum width in bits; any integer >= 1.
- GROUP, 4, lookahead group width in bits; the last group may be partial when N is not a multiple of GROUP.

Ports:
- clk  input  1  clock for the registered result only
- reset  input  1  asynchronous, active-high; clears the registered result
- a  input  N  operand A, unsigned
- b  input  N  operand B, unsigned
- c_in  input  1  carry in
- sum  output  N  combinational sum, low N bits of a+b+c_in
- c_out  output  1  combinational carry out, bit N of a+b+c_in
- sum_q  output  N  sum registered on rising clk
- c_out_q  output  1  c_out registered on rising clk

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Combinational path:
  - {c_out, sum} == a + b + c_in exactly, for all inputs and every N.
  - Zero latency; no dependency on clk or reset.
- Per-bit signals: g[i] = a[i] & b[i]; p[i] = a[i] ^ b[i].
- Group carries:
  - Each group forms its group generate G and group propagate P.
  - Group carry-in c[k+1] = G[k] | (P[k] & c[k]); c[0] = c_in.
  - The group carry chain uses lookahead equations, not a ripple through bits.
- Bit carries inside a group are computed by expanded lookahead from the group carry-in.
- sum[i] = p[i] ^ carry[i]; c_out is the carry out of the most significant bit.
- Wrap-around: overflow is reported only through c_out; sum is modulo 2^N. There is no signed-overflow flag.
- Registered path:
  - On rising clk, sum_q <= sum and c_out_q <= c_out; latency is 1 cycle.
  - While reset is high, sum_q = 0 and c_out_q = 0 immediately, independent of clk.
  - On the first rising clk after reset deasserts, the registers capture the current combinational result.
  - Reset never affects the combinational outputs.
- X on any operand bit may propagate X to sum/c_out; no X-masking is required.
- Partial last group: when N % GROUP != 0, the last group is narrower, and c_out still equals bit N of the true sum.

Decomposition:
- Shared package cpa_pkg holds:
  - the default width constant (4);
  - the default group size constant (4);
  - a function computing the number of groups, ceil(N/GROUP).
- One sub-module, cla_group:
  - parameter W;
  - inputs: W-bit a and b slices, group carry-in;
  - outputs: W-bit sum slice, group generate, group propagate.
- The top level instantiates cla_group via generate, plus the group-level lookahead carry logic and the output register.

Test Plan:
- N=4, c_in=0, a=4, b=5 -> sum=9, c_out=0; after one rising clk, sum_q=9, c_out_q=0.
- N=4, c_in=1, a=1, b=0 -> sum=2, c_out=0.
- N=4, c_in=1, a=15, b=1 -> sum=1, c_out=1 (wrap-around); sum_q=1, c_out_q=1 one cycle later.
- N=4, exhaustive sweep of a, b and c_in (512 vectors) -> {c_out,sum} == a+b+c_in each vector, and equal to the ripple-carry adder's outputs for the same stimulus.
- N=9, GROUP=4 (partial group): a=511, b=0, c_in=1 -> sum=0, c_out=1; a=256, b=255, c_in=0 -> sum=511, c_out=0.
- Reset mid-operation: registered outputs hold 9/0, then assert reset between clock edges -> sum_q=0 and c_out_q=0 immediately, while sum/c_out are unchanged; deassert reset -> the next rising edge captures the current result.

Source files
------------

// File: rtl/cpa_pkg.sv
// Shared constants and helpers for the carry-lookahead adder slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   CPA_DEFAULT_N      default operand/sum width
//   CPA_DEFAULT_GROUP  default lookahead group width
//   cpa_num_groups()   number of lookahead groups, ceil(n/group)
package cpa_pkg;

  localparam int CPA_DEFAULT_N     = 4;
  localparam int CPA_DEFAULT_GROUP = 4;

  function automatic int cpa_num_groups(input int n, input int group);
    return (n + group - 1) / group;
  endfunction

endpackage

// File: rtl/cla_group.sv
// One lookahead group: W-bit sum slice plus group generate/propagate.
// Latency: combinational, zero cycles.
// Backpressure: none; pure datapath.
//
// Ports:
//   a_i, b_i  W-bit operand slices
//   c_i       group carry-in
//   sum_o     W-bit sum slice
//   gen_o     group generate (carry out of the group with carry-in 0)
//   prop_o    group propagate (carry-in passes through every bit)
module cla_group import cpa_pkg::*; #(
  parameter int W = CPA_DEFAULT_GROUP
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  output logic [W-1:0] sum_o,
  output logic         gen_o,
  output logic         prop_o
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W-1:0] carry;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Each bit carry is a flat sum of products:
  //   carry[j] = c_i & p[0..j-1]  |  OR_m ( g[m] & p[m+1..j-1] )
  // The loops only enumerate the product terms; no term depends on
  // another bit's carry, so there is no ripple through the group.
  always_comb begin
    logic term;
    carry = '0;
    term  = 1'b0;
    for (int j = 0; j < W; j++) begin
      term = c_i;
      for (int k = 0; k < j; k++) term = term & p[k];
      carry[j] = term;
      for (int m = 0; m < j; m++) begin
        term = g[m];
        for (int k = m + 1; k < j; k++) term = term & p[k];
        carry[j] = carry[j] | term;
      end
    end
  end

  // Group generate uses the same expansion across the full width with
  // the carry-in term dropped.
  always_comb begin
    logic term;
    gen_o = 1'b0;
    term  = 1'b0;
    for (int m = 0; m < W; m++) begin
      term = g[m];
      for (int k = m + 1; k < W; k++) term = term & p[k];
      gen_o = gen_o | term;
    end
  end

  assign prop_o = &p;
  assign sum_o  = p ^ carry;

endmodule

// File: rtl/carry_lookahead_adder.sv
// N-bit two-level carry-lookahead adder with a registered result copy.
// Latency: sum/c_out combinational; sum_q/c_out_q one clk later.
// Backpressure: none; result is valid every cycle, no handshake.
//
// Ports:
//   clk, reset     clock and async active-high reset (registered copy only)
//   a, b, c_in     unsigned operands and carry-in
//   sum, c_out     combinational {c_out, sum} = a + b + c_in
//   sum_q, c_out_q registered copy of sum/c_out
module carry_lookahead_adder import cpa_pkg::*; #(
  parameter int N     = CPA_DEFAULT_N,
  parameter int GROUP = CPA_DEFAULT_GROUP
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic [N-1:0] sum_q,
  output logic         c_out_q
);

  localparam int NG = cpa_num_groups(N, GROUP);

  logic [NG-1:0] grp_gen;
  logic [NG-1:0] grp_prop;
  logic [NG:0]   grp_c;

  // The last group absorbs whatever width is left over, so it may be
  // narrower than GROUP when N is not a multiple of it.
  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    localparam int LO = gi * GROUP;
    localparam int W  = (gi == NG - 1) ? (N - LO) : GROUP;

    cla_group #(.W(W)) u_grp (
      .a_i    (a[LO +: W]),
      .b_i    (b[LO +: W]),
      .c_i    (grp_c[gi]),
      .sum_o  (sum[LO +: W]),
      .gen_o  (grp_gen[gi]),
      .prop_o (grp_prop[gi])
    );
  end

  // Group carries in flattened lookahead form:
  //   grp_c[k] = c_in & P[0..k-1]  |  OR_m ( G[m] & P[m+1..k-1] )
  always_comb begin
    logic term;
    grp_c = '0;
    term  = 1'b0;
    for (int k = 0; k <= NG; k++) begin
      term = c_in;
      for (int j = 0; j < k; j++) term = term & grp_prop[j];
      grp_c[k] = term;
      for (int m = 0; m < k; m++) begin
        term = grp_gen[m];
        for (int j = m + 1; j < k; j++) term = term & grp_prop[j];
        grp_c[k] = grp_c[k] | term;
      end
    end
  end

  assign c_out = grp_c[NG];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      sum_q   <= sum;
      c_out_q <= c_out;
    end
  end

endmodule

// File: tb/tb_carry_lookahead_adder.sv
// Scoreboard bench for carry_lookahead_adder at N=4 and N=9 (partial group).
// Latency: expects combinational result same cycle, registered one cycle later.
// Backpressure: none; one vector per clock while stimulus is active.
module tb_carry_lookahead_adder;

  logic       clk = 1'b0;
  logic       reset;

  logic [3:0] a4, b4, s4, s4q;
  logic       c4, co4, co4q;
  logic [8:0] a9, b9, s9, s9q;
  logic       c9, co9, co9q;

  always #5 clk = ~clk;

  carry_lookahead_adder #(.N(4), .GROUP(4)) dut4 (
    .clk(clk), .reset(reset), .a(a4), .b(b4), .c_in(c4),
    .sum(s4), .c_out(co4), .sum_q(s4q), .c_out_q(co4q)
  );

  carry_lookahead_adder #(.N(9), .GROUP(4)) dut9 (
    .clk(clk), .reset(reset), .a(a9), .b(b9), .c_in(c9),
    .sum(s9), .c_out(co9), .sum_q(s9q), .c_out_q(co9q)
  );

  typedef struct {
    logic [3:0] s4;
    logic       c4;
    logic [8:0] s9;
    logic       c9;
  } exp_t;

  exp_t comb_q[$];
  exp_t reg_q[$];
  logic stim_vld = 1'b0;
  logic reg_pend = 1'b0;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer addition, then split into modulo sum and carry.
  function automatic exp_t model(input int xa, input int xb, input int xc,
                                 input int ya, input int yb, input int yc);
    exp_t e;
    int t4, t9;
    t4 = xa + xb + xc;
    t9 = ya + yb + yc;
    e.s4 = 4'(t4 % 16);
    e.c4 = (t4 >= 16);
    e.s9 = 9'(t9 % 512);
    e.c9 = (t9 >= 512);
    return e;
  endfunction

  task automatic issue(input logic [3:0] xa, input logic [3:0] xb, input logic xc,
                       input logic [8:0] ya, input logic [8:0] yb, input logic yc);
    exp_t e;
    @(posedge clk);
    #1;
    a4 = xa; b4 = xb; c4 = xc;
    a9 = ya; b9 = yb; c9 = yc;
    stim_vld = 1'b1;
    e = model(int'(xa), int'(xb), int'(xc), int'(ya), int'(yb), int'(yc));
    comb_q.push_back(e);
    reg_q.push_back(e);
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1;
    stim_vld = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: combinational result is checked in the cycle it is driven,
  // the registered copy one negedge later.
  always @(negedge clk) begin
    exp_t e;
    if (reg_pend) begin
      if (reg_q.size() == 0) chk("reg_queue_underflow", 32'd1, 32'd0);
      else begin
        e = reg_q.pop_front();
        chk("sum_q_n4", 32'(s4q), 32'(e.s4));
        chk("c_out_q_n4", 32'(co4q), 32'(e.c4));
        chk("sum_q_n9", 32'(s9q), 32'(e.s9));
        chk("c_out_q_n9", 32'(co9q), 32'(e.c9));
      end
    end
    if (stim_vld) begin
      if (comb_q.size() == 0) chk("comb_queue_underflow", 32'd1, 32'd0);
      else begin
        e = comb_q.pop_front();
        chk("sum_n4", 32'(s4), 32'(e.s4));
        chk("c_out_n4", 32'(co4), 32'(e.c4));
        chk("sum_n9", 32'(s9), 32'(e.s9));
        chk("c_out_n9", 32'(co9), 32'(e.c9));
      end
    end
    reg_pend = stim_vld;
  end

  initial begin
    reset = 1'b1;
    a4 = 4'd4; b4 = 4'd5; c4 = 1'b0;
    a9 = 9'd0; b9 = 9'd0; c9 = 1'b0;
    #2;
    chk("reset_sum_q_n4", 32'(s4q), 32'd0);
    chk("reset_c_out_q_n4", 32'(co4q), 32'd0);
    chk("reset_sum_q_n9", 32'(s9q), 32'd0);
    chk("reset_comb_during_reset", 32'(s4), 32'd9);
    @(posedge clk);
    chk("reset_holds_over_edge", 32'(s4q), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed vectors, including wrap-around and the partial-group edges.
    issue(4'd4,  4'd5, 1'b0, 9'd511, 9'd0,   1'b1);
    issue(4'd1,  4'd0, 1'b1, 9'd256, 9'd255, 1'b0);
    issue(4'd15, 4'd1, 1'b1, 9'd0,   9'd0,   1'b0);
    issue(4'd15, 4'd15, 1'b1, 9'd1,  9'd510, 1'b1);
    issue(4'd4,  4'd5, 1'b0, 9'd511, 9'd511, 1'b1);
    idle(0);

    // Reset between clock edges: registers clear at once, comb path untouched.
    @(negedge clk);
    #1;
    chk("hold_sum_q_before_reset", 32'(s4q), 32'd9);
    chk("hold_c_out_q_before_reset", 32'(co4q), 32'd0);
    reset = 1'b1;
    #1;
    chk("midreset_sum_q_n4", 32'(s4q), 32'd0);
    chk("midreset_c_out_q_n4", 32'(co4q), 32'd0);
    chk("midreset_sum_q_n9", 32'(s9q), 32'd0);
    chk("midreset_c_out_q_n9", 32'(co9q), 32'd0);
    chk("midreset_sum_n4", 32'(s4), 32'd9);
    chk("midreset_c_out_n4", 32'(co4), 32'd0);
    chk("midreset_sum_n9", 32'(s9), 32'd511);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("postreset_sum_q_n4", 32'(s4q), 32'd9);
    chk("postreset_c_out_q_n4", 32'(co4q), 32'd0);
    chk("postreset_sum_q_n9", 32'(s9q), 32'd511);
    chk("postreset_c_out_q_n9", 32'(co9q), 32'd1);

    // Exhaustive N=4 sweep alongside random N=9 traffic.
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      issue(v[8:5], v[4:1], v[0],
            9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)),
            1'($urandom_range(0, 1)));
    end
    idle(2);

    chk("scoreboard_drained", 32'(comb_q.size() + reg_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
